// File: rtl/ssd_capture_pkg.sv
// Shared seven-segment definitions: active-low abcdefg hex patterns, blank code
// and capture FSM encoding. The display encoder uses the same constants.
package ssd_capture_pkg;

    localparam logic [6:0] SSD_HEX_0 = 7'b0000001;
    localparam logic [6:0] SSD_HEX_1 = 7'b1001111;
    localparam logic [6:0] SSD_HEX_2 = 7'b0010010;
    localparam logic [6:0] SSD_HEX_3 = 7'b0000110;
    localparam logic [6:0] SSD_HEX_4 = 7'b1001100;
    localparam logic [6:0] SSD_HEX_5 = 7'b0100100;
    localparam logic [6:0] SSD_HEX_6 = 7'b0100000;
    localparam logic [6:0] SSD_HEX_7 = 7'b0001111;
    localparam logic [6:0] SSD_HEX_8 = 7'b0000000;
    localparam logic [6:0] SSD_HEX_9 = 7'b0000100;
    localparam logic [6:0] SSD_HEX_A = 7'b0001000;
    localparam logic [6:0] SSD_HEX_B = 7'b1100000;
    localparam logic [6:0] SSD_HEX_C = 7'b0110001;
    localparam logic [6:0] SSD_HEX_D = 7'b1000010;
    localparam logic [6:0] SSD_HEX_E = 7'b0110000;
    localparam logic [6:0] SSD_HEX_F = 7'b0111000;
    localparam logic [6:0] SSD_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETTLING = 2'd1,
        HELD     = 2'd2
    } cap_state_t;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/ssd_decode.sv
// Inverse of the hex encoder: maps an active-low abcdefg pattern back to its
// 4-bit value; legal is low for any pattern the encoder never produces.
module ssd_decode
    import ssd_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       legal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        value = 4'h0;
        legal = 1'b1;
        case (seg)
            SSD_HEX_0: value = 4'h0;
            SSD_HEX_1: value = 4'h1;
            SSD_HEX_2: value = 4'h2;
            SSD_HEX_3: value = 4'h3;
            SSD_HEX_4: value = 4'h4;
            SSD_HEX_5: value = 4'h5;
            SSD_HEX_6: value = 4'h6;
            SSD_HEX_7: value = 4'h7;
            SSD_HEX_8: value = 4'h8;
            SSD_HEX_9: value = 4'h9;
            SSD_HEX_A: value = 4'hA;
            SSD_HEX_B: value = 4'hB;
            SSD_HEX_C: value = 4'hC;
            SSD_HEX_D: value = 4'hD;
            SSD_HEX_E: value = 4'hE;
            SSD_HEX_F: value = 4'hF;
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ssd_capture.sv
// Receive side of the multiplexed seven-segment interface: samples anode and
// segment lines, waits for a stable pattern, and rebuilds the four hex digits.
module ssd_capture
    import ssd_capture_pkg::*;
#(
    parameter int unsigned SETTLE    = 4,
    parameter int unsigned TIMEOUT_W = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    input  logic       an0,
    input  logic       an1,
    input  logic       an2,
    input  logic       an3,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] valid,
    output logic [3:0] blank,
    output logic [3:0] seg_err,
    output logic       anode_err,
    output logic       frame_done,
    output logic       stale
);

    localparam int unsigned           CNT_W     = $clog2(SETTLE + 1);
    localparam logic [CNT_W-1:0]      SETTLE_C  = CNT_W'(SETTLE);
    localparam logic [TIMEOUT_W-1:0]  STALL_MAX = '1;
    localparam logic [TIMEOUT_W-1:0]  STALL_PRE = STALL_MAX - 1'b1;

    logic [10:0]          samp, samp_d;
    logic [CNT_W-1:0]     stab_cnt, stab_eff;
    logic [TIMEOUT_W-1:0] stall_cnt;
    cap_state_t           state, state_next;
    logic [3:0]           seen, seen_next, cap_bit;
    logic [3:0]           digit_q [4];
    logic [3:0]           dec_value;
    logic                 dec_legal;
    logic                 changed, an_changed, settled, do_capture, stale_rise;

    wire [3:0] anodes = samp[10:7];
    wire [6:0] seg    = samp[6:0];

    assign changed    = (samp != samp_d);
    assign an_changed = (samp[10:7] != samp_d[10:7]);

    // stab_eff counts cycles samp has held its value, including the current one.
    assign stab_eff = changed             ? CNT_W'(1) :
                      (stab_cnt == SETTLE_C) ? SETTLE_C : stab_cnt + 1'b1;
    assign settled  = (stab_eff == SETTLE_C);

    ssd_decode u_decode (
        .seg   (seg),
        .value (dec_value),
        .legal (dec_legal)
    );

    always_comb begin
        state_next = state;
        do_capture = 1'b0;
        case (state)
            IDLE: begin
                if (anodes != 4'b0000) begin
                    do_capture = settled;
                    state_next = settled ? HELD : SETTLING;
                end
            end
            SETTLING: begin
                if (anodes == 4'b0000) begin
                    state_next = IDLE;
                end else if (settled) begin
                    do_capture = 1'b1;
                    state_next = HELD;
                end
            end
            HELD: begin
                if (changed) begin
                    if (anodes == 4'b0000) begin
                        state_next = IDLE;
                    end else begin
                        do_capture = settled;
                        state_next = settled ? HELD : SETTLING;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cap_bit    = (do_capture && is_onehot4(anodes)) ? anodes : 4'b0000;
    // A completed frame restarts the mask, keeping any capture landing that same cycle.
    assign seen_next  = ((seen == 4'b1111) ? 4'b0000 : seen) | cap_bit;
    assign stale_rise = !an_changed && (stall_cnt == STALL_PRE);
    assign stale      = (stall_cnt == STALL_MAX);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            // NOTE: the digit storage is cleared by reset as well, so outputs read 0 after reset.
            samp       <= '0;
            samp_d     <= '0;
            stab_cnt   <= '0;
            stall_cnt  <= '0;
            state      <= IDLE;
            seen       <= '0;
            valid      <= '0;
            blank      <= '0;
            seg_err    <= '0;
            anode_err  <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 4; i++) digit_q[i] <= '0;
        end else begin
            samp       <= {an3, an2, an1, an0, a, b, c, d, e, f, g};
            samp_d     <= samp;
            stab_cnt   <= stab_eff;
            state      <= state_next;
            seen       <= seen_next;
            anode_err  <= do_capture && !is_onehot4(anodes);
            frame_done <= (seen_next == 4'b1111);

            if (an_changed)     stall_cnt <= '0;
            else if (!stale)    stall_cnt <= stall_cnt + 1'b1;

            if (stale_rise) valid <= 4'b0000;

            for (int i = 0; i < 4; i++) begin
                if (cap_bit[i]) begin
                    if (seg == SSD_BLANK) begin
                        blank[i]   <= 1'b1;
                        valid[i]   <= 1'b0;
                        seg_err[i] <= 1'b0;
                    end else if (dec_legal) begin
                        digit_q[i] <= dec_value;
                        valid[i]   <= 1'b1;
                        blank[i]   <= 1'b0;
                        seg_err[i] <= 1'b0;
                    end else begin
                        seg_err[i] <= 1'b1;
                        valid[i]   <= 1'b0;
                        blank[i]   <= 1'b0;
                    end
                end
            end
        end
    end

    assign digit0 = digit_q[0];
    assign digit1 = digit_q[1];
    assign digit2 = digit_q[2];
    assign digit3 = digit_q[3];

endmodule

// File: tb/tb_ssd_capture.sv
// Directed bench for ssd_capture (SETTLE=4, TIMEOUT_W=8) plus decoder round-trip.
module tb_ssd_capture;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a, b, c, d, e, f, g;
    logic       an0, an1, an2, an3;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [3:0] valid, blank, seg_err;
    logic       anode_err, frame_done, stale;
    logic [6:0] dec_seg;
    logic [3:0] dec_value;
    logic       dec_legal;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] HEX_TBL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    always #5 clk = ~clk;

    ssd_capture #(.SETTLE(4), .TIMEOUT_W(8)) u_dut (
        .clk(clk), .rst(rst),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .an0(an0), .an1(an1), .an2(an2), .an3(an3),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .valid(valid), .blank(blank), .seg_err(seg_err),
        .anode_err(anode_err), .frame_done(frame_done), .stale(stale)
    );

    ssd_decode u_dec (.seg(dec_seg), .value(dec_value), .legal(dec_legal));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [3:0] an, input logic [6:0] seg);
        {an3, an2, an1, an0} = an;
        {a, b, c, d, e, f, g} = seg;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero();
        check("rst_digit0", 32'(digit0), 32'h0);
        check("rst_digit1", 32'(digit1), 32'h0);
        check("rst_digit2", 32'(digit2), 32'h0);
        check("rst_digit3", 32'(digit3), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_blank", 32'(blank), 32'h0);
        check("rst_seg_err", 32'(seg_err), 32'h0);
        check("rst_anode_err", 32'(anode_err), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_stale", 32'(stale), 32'h0);
    endtask

    initial begin
        logic [6:0] sweep_seg [4];
        int         fd_cnt, fd_at, ae_cnt;
        logic [3:0] fd_d3;
        logic       saw8;

        sweep_seg = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b0001000};
        drive(4'b0000, 7'b1111111);
        dec_seg = 7'b0000000;

        // Decoder round-trip against the encoder table, plus two illegal codes.
        for (int i = 0; i < 16; i++) begin
            dec_seg = HEX_TBL[i];
            #1;
            check($sformatf("dec_val_%0h", i), 32'(dec_value), 32'(i));
            check($sformatf("dec_legal_%0h", i), 32'(dec_legal), 32'h1);
        end
        dec_seg = 7'b1111110; #1;
        check("dec_illegal_g_only", 32'(dec_legal), 32'h0);
        dec_seg = 7'b1111111; #1;
        check("dec_illegal_blank", 32'(dec_legal), 32'h0);

        step(3);
        check_all_zero();
        rst = 1'b0;
        step(2);

        // First capture: latency SETTLE+1 edges.
        drive(4'b0001, 7'b0100100);
        step(4);
        check("lat_edge4_valid", 32'(valid), 32'h0);
        check("lat_edge4_digit0", 32'(digit0), 32'h0);
        step(1);
        check("lat_edge5_digit0", 32'(digit0), 32'h5);
        check("lat_edge5_valid", 32'(valid), 32'b0001);
        step(3);

        // Sweep all four digits; frame_done only with the an3 capture.
        fd_cnt = 0; fd_at = -1; fd_d3 = 4'h0;
        for (int k = 0; k < 4; k++) begin
            drive(4'(1 << k), sweep_seg[k]);
            for (int cy = 1; cy <= 8; cy++) begin
                step(1);
                if (frame_done) begin
                    fd_cnt++;
                    fd_at = k * 8 + cy;
                    fd_d3 = digit3;
                end
            end
        end
        check("sweep_fd_count", 32'(fd_cnt), 32'd1);
        check("sweep_fd_cycle", 32'(fd_at), 32'd29);
        check("sweep_fd_with_d3", 32'(fd_d3), 32'hA);
        check("sweep_digits", 32'({digit3, digit2, digit1, digit0}), 32'hA321);
        check("sweep_valid", 32'(valid), 32'b1111);

        // Glitch: a short-lived 8 must never be captured.
        saw8 = 1'b0;
        drive(4'b0010, 7'b0000000);
        for (int cy = 0; cy < 2; cy++) begin step(1); if (digit1 == 4'h8) saw8 = 1'b1; end
        drive(4'b0010, 7'b0000100);
        for (int cy = 0; cy < 8; cy++) begin step(1); if (digit1 == 4'h8) saw8 = 1'b1; end
        check("glitch_no_8", 32'(saw8), 32'h0);
        check("glitch_digit1", 32'(digit1), 32'h9);
        check("glitch_valid", 32'(valid), 32'b1111);

        // Illegal segment pattern, then blank, on digit 2.
        drive(4'b0100, 7'b1111110);
        step(8);
        check("segerr_flag", 32'(seg_err), 32'b0100);
        check("segerr_valid", 32'(valid), 32'b1011);
        check("segerr_digit2", 32'(digit2), 32'h3);
        check("segerr_blank", 32'(blank), 32'h0);
        drive(4'b0100, 7'b1111111);
        step(8);
        check("blank_flag", 32'(blank), 32'b0100);
        check("blank_seg_err", 32'(seg_err), 32'h0);
        check("blank_valid", 32'(valid), 32'b1011);
        check("blank_digit2", 32'(digit2), 32'h3);

        // Multi-hot anodes: one anode_err pulse, nothing else moves.
        ae_cnt = 0; fd_cnt = 0;
        drive(4'b0011, 7'b0000000);
        for (int cy = 0; cy < 8; cy++) begin
            step(1);
            if (anode_err) ae_cnt++;
            if (frame_done) fd_cnt++;
        end
        check("multihot_pulses", 32'(ae_cnt), 32'd1);
        check("multihot_no_frame", 32'(fd_cnt), 32'd0);
        check("multihot_digits", 32'({digit3, digit2, digit1, digit0}), 32'hA391);
        check("multihot_valid", 32'(valid), 32'b1011);
        check("multihot_blank", 32'(blank), 32'b0100);
        check("multihot_seg_err", 32'(seg_err), 32'h0);

        // Stall timeout with TIMEOUT_W=8.
        drive(4'b0000, 7'b1111111);
        step(4);
        drive(4'b1000, 7'b0000000);
        step(256);
        check("stale_before", 32'(stale), 32'h0);
        check("stale_before_digit3", 32'(digit3), 32'h8);
        check("stale_before_valid", 32'(valid), 32'b1011);
        step(1);
        check("stale_rise", 32'(stale), 32'h1);
        check("stale_valid_cleared", 32'(valid), 32'h0);
        check("stale_digits_kept", 32'({digit3, digit2, digit1, digit0}), 32'h8391);
        drive(4'b0001, 7'b0100100);
        step(1);
        check("stale_hold_edge1", 32'(stale), 32'h1);
        step(1);
        check("stale_cleared", 32'(stale), 32'h0);

        // Reset in the middle of SETTLING discards the pending capture.
        rst = 1'b1;
        step(1);
        check_all_zero();
        rst = 1'b0;
        step(4);
        check("post_rst_edge4_valid", 32'(valid), 32'h0);
        step(1);
        check("post_rst_edge5_valid", 32'(valid), 32'b0001);
        check("post_rst_digit0", 32'(digit0), 32'h5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
